// File: rtl/clock_pkg.sv
// Shared types and defaults for the clock-chain digit counters.
// Every digit instance imports this so repeat timing stays uniform across fields.
package clock_pkg;

    typedef enum logic [1:0] {IDLE, FIRST, RPT} adj_state_t;
    typedef enum logic {UP, DOWN} adj_dir_t;

    localparam int DEF_REPEAT_DELAY  = 8;
    localparam int DEF_REPEAT_PERIOD = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adj_repeat_fsm.sv
// Hold-to-repeat key handler: turns held adj_up/adj_down levels into step pulses
// (immediate step, then after REPEAT_DELAY, then every REPEAT_PERIOD edges).
module adj_repeat_fsm
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic adj_en,
    input  logic adj_up,
    input  logic adj_down,
    input  logic load,
    output logic step_up,
    output logic step_down
);

    localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [TW-1:0] DELAY_T  = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] PERIOD_T = TW'(REPEAT_PERIOD);
    localparam logic [TW-1:0] ONE_T    = TW'(1);

    adj_state_t    state, state_n;
    adj_dir_t      dir_q, dir_n, cur_dir;
    logic [TW-1:0] timer, timer_n;
    logic          locked, locked_n;
    logic          dir_valid, step;

    assign dir_valid = adj_en & (adj_up ^ adj_down);
    assign cur_dir   = adj_up ? UP : DOWN;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dir_q  <= UP;
            timer  <= '0;
            locked <= 1'b0;
        end else begin
            state  <= state_n;
            dir_q  <= dir_n;
            timer  <= timer_n;
            locked <= locked_n;
        end
    end

    // A load while a key is held locks out stepping until that key is released.
    always_comb begin
        state_n  = state;
        dir_n    = dir_q;
        timer_n  = timer;
        locked_n = locked & dir_valid;
        step     = 1'b0;
        if (load) begin
            state_n  = IDLE;
            timer_n  = '0;
            locked_n = dir_valid;
        end else if (!dir_valid) begin
            state_n = IDLE;
            timer_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!locked) begin
                        step    = 1'b1;
                        dir_n   = cur_dir;
                        timer_n = ONE_T;
                        state_n = FIRST;
                    end
                end
                FIRST, RPT: begin
                    if (cur_dir != dir_q) begin
                        state_n = IDLE;
                        timer_n = '0;
                    end else if (timer == ((state == FIRST) ? DELAY_T : PERIOD_T)) begin
                        step    = 1'b1;
                        timer_n = ONE_T;
                        state_n = RPT;
                    end else begin
                        timer_n = timer + ONE_T;
                    end
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            endcase
        end
    end

    assign step_up   = step & (cur_dir == UP);
    assign step_down = step & (cur_dir == DOWN);

endmodule

// File: rtl/count_adjust_mod.sv
// Generic modulo digit for the clock chain: counts on carry_in, manual adjust
// with hold-to-repeat, direct load, and one-cycle carry/borrow to the next digit.
module count_adjust_mod
    import clock_pkg::*;
#(
    parameter int MODULUS       = 60,
    parameter int MIN_VAL       = 0,
    parameter int WIDTH         = 6,
    parameter int RESET_VAL     = 0,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int ADJ_CARRY     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             carry_in,
    input  logic             adj_en,
    input  logic             adj_up,
    input  logic             adj_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MIN_VAL + MODULUS - 1);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
    localparam logic             ADJ_PULSE = (ADJ_CARRY != 0);

    logic             step_up, step_down;
    logic [WIDTH:0]   load_off;
    logic             load_ok;

    function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] v);
        return (v == MAX_V) ? MIN_V : v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] v);
        return (v == MIN_V) ? MAX_V : v - WIDTH'(1);
    endfunction

    adj_repeat_fsm #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_repeat (
        .clk       (clk),
        .rst       (rst),
        .adj_en    (adj_en),
        .adj_up    (adj_up),
        .adj_down  (adj_down),
        .load      (load),
        .step_up   (step_up),
        .step_down (step_down)
    );

    // Offset from MIN_VAL; values below MIN wrap to a huge offset and fail the test.
    assign load_off = {1'b0, load_val} - {1'b0, MIN_V};
    assign load_ok  = load_off < (WIDTH + 1)'(MODULUS);

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= RESET_V;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
        end else begin
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
            if (load) begin
                if (load_ok) count <= load_val;
            end else if (step_up) begin
                count     <= inc_wrap(count);
                carry_out <= ADJ_PULSE & (count == MAX_V);
            end else if (step_down) begin
                count      <= dec_wrap(count);
                borrow_out <= ADJ_PULSE & (count == MIN_V);
            end else if (carry_in && !adj_en) begin
                count     <= inc_wrap(count);
                carry_out <= (count == MAX_V);
            end
        end
    end

    assign at_max = (count == MAX_V);

endmodule

// File: tb/tb_count_adjust_mod.sv
// Randomized bench for count_adjust_mod: three parameterizations share stimulus and
// are compared each cycle against a press-duration reference model.
module tb_count_adjust_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       carry_in = 1'b0, adj_en = 1'b0, adj_up = 1'b0, adj_down = 1'b0, load = 1'b0;
    logic [5:0] load_val = '0;

    logic [5:0] count_a;
    logic [3:0] count_b, count_c;
    logic       carry_a, borrow_a, at_max_a;
    logic       carry_b, borrow_b, at_max_b;
    logic       carry_c, borrow_c, at_max_c;

    int checks = 0;
    int failures = 0;

    // Instance parameters: a = default minutes, b = 1..12 with adjust carries,
    // c = 1..12 without adjust carries and fast repeat.
    int p_mod[3] = '{60, 12, 12};
    int p_min[3] = '{0, 1, 1};
    int p_rv[3]  = '{0, 1, 1};
    int p_dly[3] = '{8, 8, 3};
    int p_per[3] = '{2, 2, 1};
    int p_ac[3]  = '{0, 1, 0};
    int p_w[3]   = '{6, 4, 4};

    int m_count[3];
    bit m_carry[3], m_borrow[3], m_press[3], m_pdir[3], m_locked[3];
    int m_h[3];

    always #5 clk = ~clk;

    count_adjust_mod u_a (
        .clk(clk), .rst(rst), .carry_in(carry_in), .adj_en(adj_en), .adj_up(adj_up),
        .adj_down(adj_down), .load(load), .load_val(load_val), .count(count_a),
        .carry_out(carry_a), .borrow_out(borrow_a), .at_max(at_max_a)
    );

    count_adjust_mod #(
        .MODULUS(12), .MIN_VAL(1), .WIDTH(4), .RESET_VAL(1),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(2), .ADJ_CARRY(1)
    ) u_b (
        .clk(clk), .rst(rst), .carry_in(carry_in), .adj_en(adj_en), .adj_up(adj_up),
        .adj_down(adj_down), .load(load), .load_val(load_val[3:0]), .count(count_b),
        .carry_out(carry_b), .borrow_out(borrow_b), .at_max(at_max_b)
    );

    count_adjust_mod #(
        .MODULUS(12), .MIN_VAL(1), .WIDTH(4), .RESET_VAL(1),
        .REPEAT_DELAY(3), .REPEAT_PERIOD(1), .ADJ_CARRY(0)
    ) u_c (
        .clk(clk), .rst(rst), .carry_in(carry_in), .adj_en(adj_en), .adj_up(adj_up),
        .adj_down(adj_down), .load(load), .load_val(load_val[3:0]), .count(count_c),
        .carry_out(carry_c), .borrow_out(borrow_c), .at_max(at_max_c)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input bit up);
        int maxv;
        maxv = p_min[i] + p_mod[i] - 1;
        if (up) begin
            if (m_count[i] == maxv) begin
                m_count[i] = p_min[i];
                m_carry[i] = (p_ac[i] != 0);
            end else m_count[i]++;
        end else begin
            if (m_count[i] == p_min[i]) begin
                m_count[i]  = maxv;
                m_borrow[i] = (p_ac[i] != 0);
            end else m_count[i]--;
        end
    endtask

    // Press model: h = edges since the press began; steps at h=0, h=DELAY, DELAY+k*PERIOD.
    task automatic model_edge(input int i);
        int  maxv, lv;
        bit  dv, d;
        maxv = p_min[i] + p_mod[i] - 1;
        lv   = int'(load_val) % (1 << p_w[i]);
        dv   = adj_en && (adj_up != adj_down);
        d    = adj_up;
        m_carry[i]  = 1'b0;
        m_borrow[i] = 1'b0;
        if (rst) begin
            m_count[i]  = p_rv[i];
            m_press[i]  = 1'b0;
            m_locked[i] = 1'b0;
        end else if (load) begin
            if (lv >= p_min[i] && lv <= maxv) m_count[i] = lv;
            m_press[i]  = 1'b0;
            m_locked[i] = dv;
        end else if (!dv) begin
            m_press[i]  = 1'b0;
            m_locked[i] = 1'b0;
            if (carry_in && !adj_en) begin
                if (m_count[i] == maxv) begin
                    m_count[i] = p_min[i];
                    m_carry[i] = 1'b1;
                end else m_count[i]++;
            end
        end else if (m_locked[i]) begin
            m_locked[i] = 1'b1;
        end else if (m_press[i] && m_pdir[i] == d) begin
            m_h[i]++;
            if (m_h[i] == p_dly[i] || (m_h[i] > p_dly[i] && (m_h[i] - p_dly[i]) % p_per[i] == 0))
                model_step(i, d);
        end else if (m_press[i]) begin
            m_press[i] = 1'b0;
        end else begin
            m_press[i] = 1'b1;
            m_pdir[i]  = d;
            m_h[i]     = 0;
            model_step(i, d);
        end
    endtask

    task automatic chk_inst(input int i, input string nm, input int cnt,
                            input logic cy, input logic bw, input logic am);
        chk({nm, ".count"},  cnt, m_count[i]);
        chk({nm, ".carry"},  int'(cy), int'(m_carry[i]));
        chk({nm, ".borrow"}, int'(bw), int'(m_borrow[i]));
        chk({nm, ".at_max"}, int'(am), int'(m_count[i] == p_min[i] + p_mod[i] - 1));
    endtask

    task automatic cyc();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        chk_inst(0, "a", int'(count_a), carry_a, borrow_a, at_max_a);
        chk_inst(1, "b", int'(count_b), carry_b, borrow_b, at_max_b);
        chk_inst(2, "c", int'(count_c), carry_c, borrow_c, at_max_c);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = 6'(v);
        cyc();
        load = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        chk("reset.a", int'(count_a), 0);
        chk("reset.b", int'(count_b), 1);
        rst = 1'b0;

        // wrap on carry_in
        do_load(59);
        carry_in = 1'b1;
        cyc();
        chk("t1.count", int'(count_a), 0);
        chk("t1.carry", int'(carry_a), 1);
        carry_in = 1'b0;
        cyc();
        chk("t1.carry_low", int'(carry_a), 0);

        // held up key: 20 edges -> 7 steps
        do_load(10);
        adj_en = 1'b1; adj_up = 1'b1;
        repeat (20) cyc();
        chk("t2.count", int'(count_a), 17);
        adj_up = 1'b0;
        repeat (5) cyc();
        chk("t2.release", int'(count_a), 17);

        // down wrap at MIN with and without adjust borrow
        adj_en = 1'b0;
        do_load(1);
        adj_en = 1'b1; adj_down = 1'b1;
        cyc();
        chk("t3.b.count", int'(count_b), 12);
        chk("t3.b.borrow", int'(borrow_b), 1);
        chk("t3.c.count", int'(count_c), 12);
        chk("t3.c.borrow", int'(borrow_c), 0);
        adj_down = 1'b0;
        cyc();
        chk("t3.b.borrow_low", int'(borrow_b), 0);

        // both keys pressed, carry_in ignored under adj_en
        adj_up = 1'b1; adj_down = 1'b1; carry_in = 1'b1;
        repeat (3) cyc();
        chk("t4.count", int'(count_a), 0);
        chk("t4.carry", int'(carry_a), 0);
        adj_up = 1'b0; adj_down = 1'b0; carry_in = 1'b0; adj_en = 1'b0;

        // load in/out of range, load during repeat
        do_load(45);
        chk("t5.load45", int'(count_a), 45);
        do_load(60);
        chk("t5.load60", int'(count_a), 45);
        adj_en = 1'b1; adj_up = 1'b1;
        repeat (12) cyc();
        chk("t5.rpt", int'(count_a), 48);
        do_load(63);
        repeat (10) cyc();
        chk("t5.locked", int'(count_a), 48);
        adj_up = 1'b0;
        cyc();
        adj_up = 1'b1;
        cyc();
        chk("t5.repress", int'(count_a), 49);
        adj_up = 1'b0;
        cyc();

        // reset while repeating
        do_load(30);
        adj_up = 1'b1;
        repeat (11) cyc();
        chk("t6.pre", int'(count_a), 33);
        rst = 1'b1;
        cyc();
        chk("t6.count", int'(count_a), 0);
        chk("t6.carry", int'(carry_a), 0);
        chk("t6.borrow", int'(borrow_a), 0);
        rst = 1'b0; adj_up = 1'b0; adj_en = 1'b0;
        cyc();

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                adj_en   = ($urandom_range(0, 2) != 0);
                adj_up   = 1'($urandom_range(0, 1));
                adj_down = 1'($urandom_range(0, 1));
            end
            carry_in = ($urandom_range(0, 3) == 0);
            load     = ($urandom_range(0, 31) == 0);
            load_val = 6'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
